alarm_clock: RTL and testbench

- 24-hour HH:MM:SS real-time clock with a button-driven time-set mode.
- Six BCD digit outputs and six matching 7-segment patterns.
- Push-button inputs (select, increment) are synchronized and debounced internally.
- Top-level timekeeping block feeding the board displays.

---
 rtl/alarm_clock_if.sv | 21 ++
 rtl/alarm_clock.sv | 215 +++++++++++++++++++++
 tb/tb_alarm_clock.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alarm_clock_if.sv
// Button/level inputs and BCD + 7-segment display outputs of the alarm clock.
// The master side drives the buttons; the slave side is the clock itself.
interface alarm_clock_if;
  logic       set_time;
  logic       switch_select_in;
  logic       increment_in;
  logic [3:0] secU, secT, minU, minT, hrU, hrT;
  logic [6:0] secUSeg, secTSeg, minUSeg, minTSeg, hrUSeg, hrTSeg;

  modport master (
    output set_time, switch_select_in, increment_in,
    input  secU, secT, minU, minT, hrU, hrT,
    input  secUSeg, secTSeg, minUSeg, minTSeg, hrUSeg, hrTSeg
  );

  modport slave (
    input  set_time, switch_select_in, increment_in,
    output secU, secT, minU, minT, hrU, hrT,
    output secUSeg, secTSeg, minUSeg, minTSeg, hrUSeg, hrTSeg
  );
endinterface

// File: rtl/alarm_clock.sv
// 24-hour HH:MM:SS clock with debounced select/increment buttons and a
// per-digit time-set mode; drives BCD digits and 7-segment patterns.
module alarm_clock #(
  parameter int TICK_CYCLES     = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic          clk,
  input  logic          resetn,
  alarm_clock_if.slave  bus
);

  localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Button index 0 = select, 1 = increment
  logic [1:0]    raw_s;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    db_q, db_d;
  logic [1:0]    press_q, press_d;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [3:0]    secu_q, sect_q, minu_q, mint_q, hru_q, hrt_q;
  logic [3:0]    secu_d, sect_d, minu_d, mint_d, hru_d, hrt_d;
  logic          tick_s;

  assign raw_s = {bus.increment_in, bus.switch_select_in};

  // Debounce: accept the synced level after DEBOUNCE_CYCLES consecutive mismatching samples
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    press_d = db_d & ~db_q;
  end

  // Prescaler, pointer and digit next-state
  always_comb begin
    presc_d = presc_q;
    ptr_d   = ptr_q;
    secu_d  = secu_q;
    sect_d  = sect_q;
    minu_d  = minu_q;
    mint_d  = mint_q;
    hru_d   = hru_q;
    hrt_d   = hrt_q;
    tick_s  = 1'b0;

    if (bus.set_time) begin
      presc_d = '0;
      if (press_q[1]) begin
        case (ptr_q)
          3'd0: secu_d = (secu_q == 4'd9) ? 4'd0 : secu_q + 4'd1;
          3'd1: sect_d = (sect_q == 4'd5) ? 4'd0 : sect_q + 4'd1;
          3'd2: minu_d = (minu_q == 4'd9) ? 4'd0 : minu_q + 4'd1;
          3'd3: mint_d = (mint_q == 4'd5) ? 4'd0 : mint_q + 4'd1;
          3'd4: begin
            if (hrt_q == 4'd2) begin
              hru_d = (hru_q >= 4'd3) ? 4'd0 : hru_q + 4'd1;
            end else begin
              hru_d = (hru_q == 4'd9) ? 4'd0 : hru_q + 4'd1;
            end
          end
          3'd5: begin
            hrt_d = (hrt_q >= 4'd2) ? 4'd0 : hrt_q + 4'd1;
            // 2x hours are limited to 23
            if (hrt_d == 4'd2 && hru_q > 4'd3) begin
              hru_d = 4'd3;
            end else begin
              hru_d = hru_q;
            end
          end
          default: ptr_d = ptr_q;
        endcase
      end else begin
        ptr_d = ptr_q;
      end
      if (press_q[0]) begin
        ptr_d = (ptr_q >= 3'd5) ? 3'd0 : ptr_q + 3'd1;
      end else begin
        ptr_d = ptr_q;
      end
    end else begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_s  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (tick_s) begin
      if (secu_q != 4'd9) begin
        secu_d = secu_q + 4'd1;
      end else begin
        secu_d = 4'd0;
        if (sect_q != 4'd5) begin
          sect_d = sect_q + 4'd1;
        end else begin
          sect_d = 4'd0;
          if (minu_q != 4'd9) begin
            minu_d = minu_q + 4'd1;
          end else begin
            minu_d = 4'd0;
            if (mint_q != 4'd5) begin
              mint_d = mint_q + 4'd1;
            end else begin
              mint_d = 4'd0;
              if (hrt_q == 4'd2 && hru_q == 4'd3) begin
                hrt_d = 4'd0;
                hru_d = 4'd0;
              end else if (hru_q == 4'd9) begin
                hru_d = 4'd0;
                hrt_d = hrt_q + 4'd1;
              end else begin
                hru_d = hru_q + 4'd1;
              end
            end
          end
        end
      end
    end else begin
      tick_s = 1'b0;
    end
  end

  // Button conditioning state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      db_q     <= 2'b00;
      press_q  <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= raw_s;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      press_q  <= press_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // Timekeeping state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q <= '0;
      ptr_q   <= 3'd4;
      secu_q  <= 4'd0;
      sect_q  <= 4'd0;
      minu_q  <= 4'd0;
      mint_q  <= 4'd0;
      hru_q   <= 4'd0;
      hrt_q   <= 4'd0;
    end else begin
      presc_q <= presc_d;
      ptr_q   <= ptr_d;
      secu_q  <= secu_d;
      sect_q  <= sect_d;
      minu_q  <= minu_d;
      mint_q  <= mint_d;
      hru_q   <= hru_d;
      hrt_q   <= hrt_d;
    end
  end

  assign bus.secU    = secu_q;
  assign bus.secT    = sect_q;
  assign bus.minU    = minu_q;
  assign bus.minT    = mint_q;
  assign bus.hrU     = hru_q;
  assign bus.hrT     = hrt_q;
  assign bus.secUSeg = seg7(secu_q);
  assign bus.secTSeg = seg7(sect_q);
  assign bus.minUSeg = seg7(minu_q);
  assign bus.minTSeg = seg7(mint_q);
  assign bus.hrUSeg  = seg7(hru_q);
  assign bus.hrTSeg  = seg7(hrt_q);

endmodule

// File: tb/tb_alarm_clock.sv
// Directed table-driven bench for alarm_clock (TICK_CYCLES=4, DEBOUNCE_CYCLES=8);
// expected times are packed as 24'hHHMMSS digit nibbles.
module tb_alarm_clock;
  localparam int OP_WAIT = 0, OP_RST = 1, OP_SETL = 2, OP_SEL = 3, OP_INC = 4, OP_GLITCH = 5;
  localparam int PRESS_LEN = 28;

  typedef struct {
    int          op;
    int          arg;
    logic [23:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs [64];
  int   nv = 0;
  logic [6:0] seg_tab [10];

  alarm_clock_if bus ();

  alarm_clock #(.TICK_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input int op, input int arg, input logic [23:0] exp);
    vecs[nv].op  = op;
    vecs[nv].arg = arg;
    vecs[nv].exp = exp;
    nv++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic s, input logic i, input int hi);
    bus.switch_select_in = s;
    bus.increment_in     = i;
    step(hi);
    bus.switch_select_in = 1'b0;
    bus.increment_in     = 1'b0;
    step(PRESS_LEN - hi);
  endtask

  task automatic check(input string name, input logic [23:0] exp);
    logic [23:0] got;
    logic [41:0] got_seg, exp_seg;
    got     = {bus.hrT, bus.hrU, bus.minT, bus.minU, bus.secT, bus.secU};
    got_seg = {bus.hrTSeg, bus.hrUSeg, bus.minTSeg, bus.minUSeg, bus.secTSeg, bus.secUSeg};
    for (int k = 0; k < 6; k++) begin
      exp_seg[k*7 +: 7] = seg_tab[int'(exp[k*4 +: 4])];
    end
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s time: got %h required %h", name, got, exp);
    end
    n_cmp++;
    if (got_seg !== exp_seg) begin
      n_bad++;
      $display("FAIL %s segs: got %b required %b", name, got_seg, exp_seg);
    end
  endtask

  initial begin
    seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    add(OP_WAIT,   16,  24'h000004);
    add(OP_WAIT,   220, 24'h000059);
    add(OP_WAIT,   4,   24'h000100);
    add(OP_RST,    0,   24'h000000);
    add(OP_SETL,   1,   24'h000000);
    add(OP_GLITCH, 0,   24'h000000);
    add(OP_SEL,    2,   24'h000000);
    add(OP_INC,    1,   24'h000001);
    add(OP_INC,    12,  24'h000003);
    add(OP_SEL,    1,   24'h000003);
    add(OP_INC,    2,   24'h000023);
    add(OP_SEL,    1,   24'h000023);
    add(OP_INC,    5,   24'h000523);
    add(OP_SEL,    1,   24'h000523);
    add(OP_INC,    5,   24'h005523);
    add(OP_SETL,   0,   24'h005523);
    add(OP_WAIT,   3,   24'h005523);
    add(OP_WAIT,   1,   24'h005524);
    add(OP_WAIT,   144, 24'h005600);
    add(OP_SETL,   1,   24'h005600);
    add(OP_SEL,    1,   24'h005600);
    add(OP_INC,    9,   24'h095600);
    add(OP_SEL,    1,   24'h095600);
    add(OP_INC,    1,   24'h195600);
    add(OP_INC,    1,   24'h235600);
    add(OP_SEL,    5,   24'h235600);
    add(OP_INC,    1,   24'h205600);
    add(OP_SEL,    1,   24'h205600);
    add(OP_INC,    1,   24'h005600);
    add(OP_INC,    2,   24'h205600);
    add(OP_SEL,    1,   24'h205600);
    add(OP_INC,    9,   24'h205609);
    add(OP_SEL,    1,   24'h205609);
    add(OP_INC,    5,   24'h205659);
    add(OP_SEL,    1,   24'h205659);
    add(OP_INC,    3,   24'h205959);
    add(OP_SEL,    2,   24'h205959);
    add(OP_INC,    3,   24'h235959);
    add(OP_SETL,   0,   24'h235959);
    add(OP_WAIT,   4,   24'h000000);

    resetn               = 1'b0;
    bus.set_time         = 1'b0;
    bus.switch_select_in = 1'b0;
    bus.increment_in     = 1'b0;
    step(2);
    check("reset", 24'h000000);
    resetn = 1'b1;

    for (int r = 0; r < nv; r++) begin
      case (vecs[r].op)
        OP_WAIT: step(vecs[r].arg);
        OP_RST: begin
          resetn = 1'b0;
          step(2);
          resetn = 1'b1;
        end
        OP_SETL: bus.set_time = (vecs[r].arg != 0);
        OP_SEL: for (int k = 0; k < vecs[r].arg; k++) press(1'b1, 1'b0, 13);
        OP_INC: for (int k = 0; k < vecs[r].arg; k++) press(1'b0, 1'b1, 13);
        OP_GLITCH: begin
          press(1'b1, 1'b1, 3);
          press(1'b1, 1'b0, 3);
          press(1'b0, 1'b1, 3);
        end
        default: step(1);
      endcase
      check($sformatf("row%0d", r), vecs[r].exp);
    end

    // Reset in the middle of set mode, then frozen time and pointer behaviour
    bus.set_time = 1'b1;
    press(1'b0, 1'b1, 13);
    check("pre_rst", 24'h010000);
    resetn = 1'b0;
    #2;
    check("async_rst", 24'h000000);
    step(1);
    resetn = 1'b1;
    step(12);
    check("frozen", 24'h000000);
    press(1'b1, 1'b1, 13);
    check("sim_press", 24'h010000);
    press(1'b0, 1'b1, 13);
    check("ptr_after_sim", 24'h110000);
    bus.set_time = 1'b0;
    press(1'b0, 1'b1, 13);
    check("run_inc_ignored", 24'h110007);
    press(1'b1, 1'b0, 13);
    check("run_sel_ignored", 24'h110014);
    bus.set_time = 1'b1;
    press(1'b0, 1'b1, 13);
    check("ptr_retained", 24'h210014);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
